// File: rtl/mig_eval_pkg.sv
// Shared types and constants for the sequential majority-inverter-graph evaluator.
// Build option: MIG_EVAL_INV_EN enables per-operand inversion.
package mig_eval_pkg;

  localparam int MAX_SEL_W = 7;  // clog2(1+32+64)
  localparam int ZERO_IDX  = 0;
  localparam int IN_BASE   = 1;

`ifdef MIG_EVAL_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  typedef struct packed {
    logic                 inv;
    logic [MAX_SEL_W-1:0] sel;
  } operand_t;

  typedef struct packed {
    operand_t c;
    operand_t b;
    operand_t a;
  } gate_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/mig_maj3.sv
// Three-input majority with per-operand inversion; shared by every gate slot.
module mig_maj3 (
  input  logic [2:0] v,
  input  logic [2:0] inv,
  output logic       y
);
  logic [2:0] e;

  assign e = v ^ inv;
  assign y = (e[0] & e[1]) | (e[0] & e[2]) | (e[1] & e[2]);
endmodule

// File: rtl/mig_eval.sv
// Programmable majority-inverter-graph evaluator, one gate per cycle, valid/ready I/O.
// Build option: MIG_EVAL_INV_EN honours the inv bits; otherwise they read as 0.
module mig_eval import mig_eval_pkg::*; #(
  parameter  int NUM_IN    = 7,
  parameter  int NUM_GATES = 6,
  localparam int SEL_W     = clog2(1 + NUM_IN + NUM_GATES),
  localparam int AW        = (NUM_GATES > 1) ? clog2(NUM_GATES) : 1,
  localparam int OW        = SEL_W + 1,
  localparam int DW        = 3 * OW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [DW-1:0]     cfg_data,
  input  logic [SEL_W-1:0]  cfg_out_sel,
  input  logic              cfg_out_we,
  output logic              cfg_busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NUM_IN-1:0] x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out,
  output logic              err
);

  localparam int NODES = 1 << SEL_W;

  state_t                 state, state_nxt;
  logic [AW-1:0]          k;
  gate_t                  slots [NUM_GATES];
  logic [SEL_W-1:0]       out_sel;
  logic [NUM_GATES-1:0]   w, w_nxt;
  logic [NUM_IN-1:0]      xr;
  logic [NODES-1:0]       nodes, nodes_nxt;
  gate_t                  g;
  operand_t [2:0]         gops;
  logic [2:0]             opv, opinv, opbad;
  logic                   res, last;

  function automatic gate_t unpack(input logic [DW-1:0] d);
    gate_t r;
    r.a.sel = MAX_SEL_W'(d[0 +: SEL_W]);
    r.a.inv = d[SEL_W];
    r.b.sel = MAX_SEL_W'(d[OW +: SEL_W]);
    r.b.inv = d[OW + SEL_W];
    r.c.sel = MAX_SEL_W'(d[2*OW +: SEL_W]);
    r.c.inv = d[2*OW + SEL_W];
    return r;
  endfunction

  assign in_ready  = (state == IDLE);
  assign cfg_busy  = (state != IDLE);
  assign out_valid = (state == DONE);
  assign last      = (int'(k) == NUM_GATES - 1);

  // Node space is padded to a power of two so out-of-range indices read 0.
  always_comb begin
    nodes                         = '0;
    nodes[ZERO_IDX]               = 1'b0;
    nodes[IN_BASE +: NUM_IN]      = xr;
    nodes[NUM_IN + 1 +: NUM_GATES] = w;
  end

  always_comb begin
    nodes_nxt                          = nodes;
    nodes_nxt[NUM_IN + 1 +: NUM_GATES] = w_nxt;
  end

  // Gate k may only see nodes below its own index; anything else is a fault.
  always_comb begin
    g     = slots[k];
    gops  = {g.c, g.b, g.a};
    opbad = '0;
    opv   = '0;
    opinv = '0;
    for (int i = 0; i < 3; i++) begin
      opbad[i] = int'(gops[i].sel) >= NUM_IN + 1 + int'(k);
      opv[i]   = opbad[i] ? 1'b0 : nodes[gops[i].sel[SEL_W-1:0]];
      opinv[i] = gops[i].inv & INV_EN;
    end
  end

  mig_maj3 u_maj (
    .v   (opv),
    .inv (opinv),
    .y   (res)
  );

  always_comb begin
    w_nxt    = w;
    w_nxt[k] = res;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = EVAL;
      EVAL:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      out_sel <= SEL_W'(NUM_IN + NUM_GATES);
      w       <= '0;
      xr      <= '0;
      out     <= 1'b0;
      err     <= 1'b0;
      for (int j = 0; j < NUM_GATES; j++) slots[j] <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (cfg_we && int'(cfg_addr) < NUM_GATES) slots[cfg_addr] <= unpack(cfg_data);
        if (cfg_out_we) out_sel <= cfg_out_sel;
        if (in_valid) begin
          xr <= x;
          k  <= '0;
        end
      end
      if (state == EVAL) begin
        w <= w_nxt;
        k <= k + 1'b1;
        if (|opbad) err <= 1'b1;
        // The final gate's result is still in flight, so sample the next-state view.
        if (last) out <= nodes_nxt[out_sel];
      end
    end
  end

endmodule
